// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder sequencer: FSM state encoding,
// default geometry and the named per-round stage positions.
package encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_ROUNDS     = 24;

    // Issue order within one round.
    localparam int STG_PARITY  = 0;
    localparam int STG_ROTATE  = 1;
    localparam int STG_PERMUTE = 2;
    localparam int STG_REVAL   = 3;
    localparam int STG_ADDRC   = 4;

endpackage

// File: rtl/encoder_sequencer_if.sv
// Host and stage-unit handshake bundle of the encoder sequencer.
// master = the sequencer, slave = host plus stage units.
interface encoder_sequencer_if
    import encoder_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int RW         = 5,
    parameter int SW         = 3
);
    logic                  start;
    logic                  ready;
    logic                  done;
    logic                  rd_in;
    logic                  wr_out;
    logic [NUM_STAGES-1:0] stg_start;
    logic [NUM_STAGES-1:0] stg_ready;
    logic [RW-1:0]         round;
    logic [SW-1:0]         stage;

    modport master (
        input  start, stg_ready,
        output ready, done, rd_in, wr_out, stg_start, round, stage
    );

    modport slave (
        output start, stg_ready,
        input  ready, done, rd_in, wr_out, stg_start, round, stage
    );
endinterface

// File: rtl/enc_round_counter.sv
// Stage/round position counter: stage steps on inc and carries into round;
// clr returns both to zero. Neither wraps on its own.
module enc_round_counter
    import encoder_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int ROUNDS     = DEF_ROUNDS,
    parameter int RW         = 5,
    parameter int SW         = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [SW-1:0] stage,
    output logic [RW-1:0] round,
    output logic          last_stage,
    output logic          last_round
);

    logic [SW-1:0] stage_reg;
    logic [RW-1:0] round_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= '0;
            round_reg <= '0;
        end else if (clr) begin
            stage_reg <= '0;
            round_reg <= '0;
        end else if (inc) begin
            if (last_stage) begin
                stage_reg <= '0;
                round_reg <= round_reg + 1'b1;
            end else begin
                stage_reg <= stage_reg + 1'b1;
            end
        end
    end

    assign last_stage = (stage_reg == SW'(NUM_STAGES - 1));
    assign last_round = (round_reg == RW'(ROUNDS - 1));
    assign stage      = stage_reg;
    assign round      = round_reg;

endmodule

// File: rtl/encoder_sequencer.sv
// Encoder top-level control: load one block, run every stage unit in order
// for ROUNDS rounds, store the result and pulse done.
module encoder_sequencer
    import encoder_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int ROUNDS     = DEF_ROUNDS,
    parameter int RW         = 5,
    parameter int SW         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_sequencer_if.master  bus
);

    state_t                state_reg;
    state_t                state_next;
    logic                  cnt_inc;
    logic                  cnt_clr;
    logic [SW-1:0]         stage_cnt;
    logic [RW-1:0]         round_cnt;
    logic                  last_stage;
    logic                  last_round;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  sel_ready;

    enc_round_counter #(
        .NUM_STAGES (NUM_STAGES),
        .ROUNDS     (ROUNDS),
        .RW         (RW),
        .SW         (SW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .stage      (stage_cnt),
        .round      (round_cnt),
        .last_stage (last_stage),
        .last_round (last_round)
    );

    // Only the current stage's ready bit is ever looked at.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
            assign stage_onehot[gi] = (stage_cnt == SW'(gi));
        end
    endgenerate

    assign sel_ready = |(bus.stg_ready & stage_onehot);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_ISSUE;
            ST_ISSUE: if (sel_ready) state_next = ST_GUARD;
            // The stage still shows ready the cycle after it took start.
            ST_GUARD: state_next = ST_WAIT;
            ST_WAIT: begin
                if (sel_ready) begin
                    if (last_stage && last_round) begin
                        state_next = ST_WRITE;
                    end else begin
                        cnt_inc    = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_WRITE: state_next = ST_DONE;
            ST_DONE: begin
                cnt_clr    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.ready     = (state_reg == ST_IDLE);
        bus.rd_in     = (state_reg == ST_LOAD);
        bus.wr_out    = (state_reg == ST_WRITE);
        bus.done      = (state_reg == ST_DONE);
        bus.stg_start = '0;
        if (state_reg == ST_ISSUE) begin
            bus.stg_start = stage_onehot & bus.stg_ready;
        end
        bus.round = round_cnt;
        bus.stage = stage_cnt;
    end

endmodule

// File: tb/tb_encoder_sequencer.sv
// Scoreboard bench for encoder_sequencer (ROUNDS=2): runs push expected
// events with their cycle numbers, a negedge monitor pops and compares.
module tb_encoder_sequencer;
    import encoder_pkg::*;

    localparam int NS = 5;
    localparam int NR = 2;

    typedef struct {
        int         kind;   // 0 rd_in, 1 stage issue, 2 wr_out, 3 done, 4 ready rise
        int         cyc;
        logic [4:0] onehot;
        int         rnd;
        int         stg;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  exp_q[$];
    int   lat_cfg[NS];
    int   hold_cfg[NS];
    int   busy[NS];
    logic [4:0] noise;
    logic noise_en;
    logic ready_prev;

    encoder_sequencer_if #(.NUM_STAGES(NS), .RW(5), .SW(3)) bus ();

    encoder_sequencer #(
        .NUM_STAGES (NS),
        .ROUNDS     (NR),
        .RW         (5),
        .SW         (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= 5'($urandom);
        for (int i = 0; i < NS; i++) begin
            if (bus.stg_start[i]) busy[i] <= lat_cfg[i];
            else if (busy[i] > 0) busy[i] <= busy[i] - 1;
        end
    end

    // Stage models plus optional random noise on the non-current stages.
    always_comb begin
        bus.stg_ready = '0;
        for (int i = 0; i < NS; i++) begin
            bus.stg_ready[i] = ((busy[i] == 0) && (cyc >= hold_cfg[i]))
                             ^ (noise_en && noise[i] && (int'(bus.stage) != i));
        end
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        logic ok;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
        end else begin
            e  = exp_q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc);
            if (kind == 1) begin
                ok = ok && (bus.stg_start == e.onehot) && (int'(bus.round) == e.rnd)
                        && (int'(bus.stage) == e.stg);
            end
            if (!ok) begin
                fails++;
                $display("FAIL event: got kind %0d cyc %0d start %b round %0d stage %0d, required kind %0d cyc %0d start %b round %0d stage %0d",
                         kind, cyc, bus.stg_start, bus.round, bus.stage,
                         e.kind, e.cyc, e.onehot, e.rnd, e.stg);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ready_prev = 1'b1;
        end else begin
            if (bus.rd_in) check_ev(0);
            if (bus.stg_start != '0) check_ev(1);
            if (bus.wr_out) check_ev(2);
            if (bus.done) check_ev(3);
            if (bus.ready && !ready_prev) check_ev(4);
            ready_prev = bus.ready;
        end
    end

    function automatic ev_t mk(input int kind, input int c, input logic [4:0] oh,
                               input int r, input int s);
        ev_t e;
        e.kind = kind; e.cyc = c; e.onehot = oh; e.rnd = r; e.stg = s;
        return e;
    endfunction

    // Cycle 'base' is the IDLE cycle whose closing edge samples start.
    task automatic push_run(input int base, output int wa);
        int t, it, rdy;
        logic [4:0] oh;
        exp_q.push_back(mk(0, base + 1, 5'b0, 0, 0));
        t = base + 2;
        for (int r = 0; r < NR; r++) begin
            for (int s = 0; s < NS; s++) begin
                it  = (t > hold_cfg[s]) ? t : hold_cfg[s];
                oh  = 5'b00001 << s;
                exp_q.push_back(mk(1, it, oh, r, s));
                rdy = it + lat_cfg[s] + 1;
                t   = (it + 3 > rdy + 1) ? it + 3 : rdy + 1;
            end
        end
        exp_q.push_back(mk(2, t, 5'b0, 0, 0));
        exp_q.push_back(mk(3, t + 1, 5'b0, 0, 0));
        exp_q.push_back(mk(4, t + 2, 5'b0, 0, 0));
        wa = t;
    endtask

    task automatic wait_q(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called at a negedge; raises start for exactly one sampling edge.
    task automatic run_one(input string name);
        int wa;
        push_run(cyc, wa);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_q(name, 300);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},     int'(bus.ready), 1);
        chk({tag, "_round"},     int'(bus.round), 0);
        chk({tag, "_stage"},     int'(bus.stage), 0);
        chk({tag, "_rd_in"},     int'(bus.rd_in), 0);
        chk({tag, "_wr_out"},    int'(bus.wr_out), 0);
        chk({tag, "_done"},      int'(bus.done), 0);
        chk({tag, "_stg_start"}, int'(bus.stg_start), 0);
    endtask

    initial begin
        int wa, base2;
        rst       = 1'b0;
        bus.start = 1'b0;
        noise_en  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            lat_cfg[i]  = 2;
            hold_cfg[i] = 0;
            busy[i]     = 0;
        end

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_one("nominal");

        lat_cfg[STG_PERMUTE] = 10;
        run_one("slow_stage");
        lat_cfg[STG_PERMUTE] = 2;

        // Stage 3 would naturally issue at base+14; held busy until base+20.
        hold_cfg[STG_REVAL] = cyc + 20;
        run_one("busy_at_issue");
        hold_cfg[STG_REVAL] = 0;

        // start held high: one run, then a second from the single IDLE cycle.
        push_run(cyc, wa);
        base2 = wa + 2;
        push_run(base2, wa);
        bus.start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cyc > base2) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_q("start_abuse", 300);

        noise_en = 1'b1;
        run_one("foreign_ready");
        noise_en = 1'b0;

        // Abort mid-run with round 1, stage 1 active.
        push_run(cyc, wa);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (27) @(negedge clk);
        chk("pre_reset_round", int'(bus.round), 1);
        #2 rst = 1'b0;
        #1 chk_idle_outputs("mid_run_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        run_one("after_reset");

        repeat (5) @(negedge clk);
        chk("trailing_events", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/encoder_sequencer.md
# encoder_sequencer

Top-level control unit for the encoder function. Runs the per-round stage units (column parity, rotate, permutation, revaluate, add-round-constant) in fixed order for ROUNDS rounds. Drives each stage's start/ready handshake, reads one input block from state memory before round 0, and writes the result back after the last round. Sits above the stage controllers, exposing a single start/ready/done interface to the testbench or host.

## Interface
- NUM_STAGES, 5, stage units per round; index 0 issued first
- ROUNDS, 24, rounds per encode run
- RW, 5, round counter width; must satisfy 2^RW >= ROUNDS
- SW, 3, stage index width; must satisfy 2^SW >= NUM_STAGES
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse at the end of a run
- rd_in  out  1  one-cycle pulse; state memory loads the input block
- wr_out  out  1  one-cycle pulse; state memory stores the result
- stg_start  out  NUM_STAGES  one-hot start pulse to the current stage
- stg_ready  in  NUM_STAGES  per-stage ready; high while that stage is idle
- round  out  RW  current round index; feeds the add-round-constant unit
- stage  out  SW  current stage index; datapath mux select

## Operation
- States are IDLE, LOAD, ISSUE, GUARD, WAIT, WRITE and DONE.
- IDLE: ready=1; round=0, stage=0. If start=1, go to LOAD.
- LOAD: rd_in=1 for one cycle, then go to ISSUE.
- ISSUE: stg_start[stage] = stg_ready[stage]. Go to GUARD only when stg_ready[stage]=1; otherwise stall in ISSUE with no start asserted.
- GUARD: stg_ready is ignored for one cycle, because a stage still shows ready in the cycle after it samples start. Then go to WAIT.
- WAIT: hold until stg_ready[stage]=1, then:
  - if stage < NUM_STAGES-1: stage+1, go to ISSUE;
  - else if round < ROUNDS-1: stage=0, round+1, go to ISSUE;
  - else go to WRITE.
- WRITE: wr_out=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- round and stage never wrap mid-run. Both return to 0 only on entry to IDLE.
- start is ignored in every state except IDLE. If start is still high in the IDLE cycle after DONE, a new run begins.
- stg_ready bits other than the current stage's are ignored.
- Reset mid-run: the run is abandoned and the block goes straight to IDLE. No wr_out or done is produced.

## Timing
- Reset values: state=IDLE, ready=1, round=0, stage=0; done, rd_in, wr_out and stg_start all 0.
- All outputs except stg_start depend on registered state only. stg_start is additionally gated by stg_ready.
- Stage cost is 4 cycles when the stage's ready is low for 2 cycles after start (ISSUE, GUARD, WAIT, WAIT).
- Per-stage timing, with ISSUE at cycle t:
  - ready drops at t+1 and rises at t+3;
  - the next stage's ISSUE is at t+4.
- Run latency, with start sampled at edge 0:
  - LOAD at cycle 1; first ISSUE at cycle 2;
  - WRITE at 2+4·ROUNDS·NUM_STAGES; DONE one cycle after WRITE; ready=1 the cycle after DONE.

## Structure
- Shared package encoder_pkg holds:
  - the state enum;
  - NUM_STAGES and ROUNDS defaults;
  - named stage indices STG_PARITY, STG_ROTATE, STG_PERMUTE, STG_REVAL, STG_ADDRC.
- Sub-module enc_round_counter: a stage/round counter pair with inc and clr inputs, plus last_stage and last_round flags. The FSM uses those flags for its WAIT-exit decision.

## Test plan
- Reset behaviour: drive rst=0 mid-run, then release. Expect ready=1, round=0, stage=0 and all pulses 0 immediately. The next start runs a full sequence.
- Nominal run: ROUNDS=2, NUM_STAGES=5, stage models whose ready is low for 2 cycles after start. Expect:
  - rd_in at cycle 1;
  - stg_start one-hot at cycles 2, 6, …, 38, in order 0–4, 0–4;
  - round changes at cycle 22;
  - wr_out at 42, done at 43, ready at 44.
- Slow stage: stage 2 holds ready low for 10 cycles. Expect the sequencer to stay in WAIT and the next issue at t+12.
- Busy stage at issue: stg_ready[3]=0 when ISSUE is reached. Expect no stg_start until the bit rises, then exactly one pulse.
- Start abuse: start held high throughout a run. Expect a single run, then an immediate second run from IDLE, and no extra rd_in.
- Foreign ready: toggle stg_ready of non-current stages randomly. Expect sequence and timing identical to the nominal run.
